cnt_sched: RTL and testbench

//  Round-robin scheduler sharing one mod-(limit+1) up-counter among N_REQ requesters.

---
 rtl/cnt_sched_if.sv | 34 +++
 rtl/cnt_sched.sv | 136 +++++++++++++
 tb/tb_cnt_sched.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_sched_if.sv
// Handshake bundle between requesting control logic and cnt_sched.
//   enable  : counter advance enable
//   req     : per-requester run request (level)
//   limit   : packed terminal values, slice i = limit[i*WIDTH +: WIDTH]
//   gnt     : one-hot grant, high for the whole run
//   busy    : run in progress
//   q       : shared counter value
//   done    : 1-cycle completion pulse
//   done_id : index of the finished requester
// master = requesting side, slave = scheduler.
interface cnt_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int WIDTH = 8
);
  logic                   enable;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] limit;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic [WIDTH-1:0]       q;
  logic                   done;
  logic [ID_W-1:0]        done_id;

  modport master (
    output enable, req, limit,
    input  gnt, busy, q, done, done_id
  );

  modport slave (
    input  enable, req, limit,
    output gnt, busy, q, done, done_id
  );
endinterface

// File: rtl/cnt_sched.sv
// Round-robin scheduler sharing one mod-(limit+1) up-counter among N_REQ
// requesters. Each granted requester gets one count run from 0 to its own
// limit (latched at grant), followed by a 1-cycle done pulse.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous, active-low reset
//   bus : cnt_sched_if.slave (enable, req, limit in; gnt, busy, q, done, done_id out)
// Optional feature: define CNT_SCHED_ABORT_EN to abort a run (no done pulse)
// when the granted requester drops its req; abort wins over completion.
module cnt_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  cnt_sched_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state, state_n;
  logic [ID_W-1:0]  ptr, ptr_n;
  logic [ID_W-1:0]  winner, winner_n;
  logic [WIDTH-1:0] lim_r, lim_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic [N_REQ-1:0] gnt_r, gnt_n;
  logic             done_r, done_n;
  logic [ID_W-1:0]  done_id_r, done_id_n;

  logic             found;
  logic [ID_W-1:0]  pick;
  logic [N_REQ-1:0] rot;
  int unsigned      idx;
  int unsigned      base;
  logic [ID_W-1:0]  next_ptr;
  logic             win_req;

  // First set request at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    rot   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(ptr) + i) % N_REQ;
      rot = bus.req >> idx;
      if (!found && rot[0]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
    base = 32'(pick) * WIDTH;
  end

  assign next_ptr = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
  assign win_req  = |(bus.req & (N_REQ'(1) << winner));

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    winner_n  = winner;
    lim_n     = lim_r;
    q_n       = q_r;
    gnt_n     = gnt_r;
    done_n    = 1'b0;
    done_id_n = done_id_r;
    unique case (state)
      IDLE: begin
        if (bus.enable && found) begin
          winner_n = pick;
          gnt_n    = N_REQ'(1) << pick;
          q_n      = '0;
          lim_n    = bus.limit[base +: WIDTH];
          state_n  = COUNT;
        end
      end
      COUNT: begin
`ifdef CNT_SCHED_ABORT_EN
        if (!win_req) begin
          q_n     = '0;
          gnt_n   = '0;
          ptr_n   = next_ptr;
          state_n = IDLE;
        end else
`endif
        if (bus.enable) begin
          if (q_r == lim_r) begin
            q_n       = '0;
            gnt_n     = '0;
            done_n    = 1'b1;
            done_id_n = winner;
            ptr_n     = next_ptr;
            state_n   = DONE;
          end else begin
            q_n = q_r + WIDTH'(1);
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      winner    <= '0;
      lim_r     <= '0;
      q_r       <= '0;
      gnt_r     <= '0;
      done_r    <= 1'b0;
      done_id_r <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      winner    <= winner_n;
      lim_r     <= lim_n;
      q_r       <= q_n;
      gnt_r     <= gnt_n;
      done_r    <= done_n;
      done_id_r <= done_id_n;
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.busy    = |gnt_r;
  assign bus.q       = q_r;
  assign bus.done    = done_r;
  assign bus.done_id = done_id_r;

  logic unused_req;
  assign unused_req = win_req;

endmodule

// File: tb/tb_cnt_sched.sv
// Self-checking bench for cnt_sched: directed scenarios plus randomized
// traffic compared every cycle against a run-level reference model.
module tb_cnt_sched;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cnt_sched_if #(.N_REQ(N_REQ), .ID_W(ID_W), .WIDTH(WIDTH)) bus ();

  cnt_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a run is (owner, elapsed count, latched limit);
  // a finished run leaves one done cycle before arbitration resumes.
  bit m_run, m_fin;
  int m_cur, m_q, m_lim, m_ptr, m_done_id;

  // Observed run statistics.
  int grant_q[$];
  int len_q[$];
  int id_q[$];
  int run_len;
  logic [N_REQ-1:0] prev_gnt;

  function automatic int onehot_idx(input logic [N_REQ-1:0] v);
    for (int k = 0; k < N_REQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic model_step();
    bit ab;
    ab = 1'b0;
    if (!rst) begin
      m_run = 0; m_fin = 0; m_q = 0; m_ptr = 0; m_done_id = 0; m_cur = 0;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (m_run) begin
`ifdef CNT_SCHED_ABORT_EN
      ab = !bus.req[m_cur];
`endif
      if (ab) begin
        m_run = 0; m_q = 0; m_ptr = (m_cur + 1) % N_REQ;
      end else if (bus.enable) begin
        if (m_q == m_lim) begin
          m_run = 0; m_fin = 1; m_q = 0; m_done_id = m_cur;
          m_ptr = (m_cur + 1) % N_REQ;
        end else begin
          m_q++;
        end
      end
    end else if (bus.enable && bus.req != 0) begin
      for (int k = 0; k < N_REQ; k++) begin
        int c;
        c = (m_ptr + k) % N_REQ;
        if (bus.req[c]) begin
          m_cur = c;
          break;
        end
      end
      m_run = 1; m_q = 0;
      m_lim = int'(bus.limit[m_cur*WIDTH +: WIDTH]);
    end
  endtask

  task automatic tick();
    logic [N_REQ-1:0] eg;
    @(posedge clk);
    model_step();
    #1;
    eg = m_run ? (N_REQ'(1) << m_cur) : '0;
    check("gnt", 32'(bus.gnt), 32'(eg));
    check("busy", 32'(bus.busy), 32'(m_run));
    check("q", 32'(bus.q), 32'(m_q));
    check("done", 32'(bus.done), 32'(m_fin));
    check("done_id", 32'(bus.done_id), 32'(m_done_id));
    if (bus.gnt != 0) begin
      if (prev_gnt == 0) begin
        grant_q.push_back(onehot_idx(bus.gnt));
        run_len = 0;
      end
      run_len++;
    end
    if (bus.done) begin
      len_q.push_back(run_len);
      id_q.push_back(int'(bus.done_id));
    end
    prev_gnt = bus.gnt;
  endtask

  task automatic set_limit(input int i, input int v);
    bus.limit[i*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    grant_q.delete(); len_q.delete(); id_q.delete();
    run_len = 0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      tick();
      seen = bus.done;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.req    = '0;
    bus.limit  = '0;
    prev_gnt   = '0;
    run_len    = 0;

    // T1: reset with every requester asking.
    bus.req = 4'b1111;
    for (int i = 0; i < N_REQ; i++) set_limit(i, 2);
    rst = 1'b0;
    tick(); tick();
    check("t1_gnt", 32'(bus.gnt), 32'd0);
    check("t1_q", 32'(bus.q), 32'd0);
    check("t1_busy", 32'(bus.busy), 32'd0);
    check("t1_done", 32'(bus.done), 32'd0);

    // T3: round robin, all limits 2.
    rst = 1'b1;
    grant_q.delete(); len_q.delete(); id_q.delete();
    for (int c = 0; c < 26; c++) tick();
    check("t3_grants", 32'(grant_q.size() >= 5), 32'd1);
    if (grant_q.size() >= 5) begin
      check("t3_g0", 32'(grant_q[0]), 32'd0);
      check("t3_g1", 32'(grant_q[1]), 32'd1);
      check("t3_g2", 32'(grant_q[2]), 32'd2);
      check("t3_g3", 32'(grant_q[3]), 32'd3);
      check("t3_g4", 32'(grant_q[4]), 32'd0);
    end
    foreach (len_q[k]) check("t3_len", 32'(len_q[k]), 32'd3);

    // T2: single run, limit 10.
    bus.req = 4'b0001;
    set_limit(0, 10);
    reset_dut();
    run_until_done("t2_timeout", 40);
    bus.req = '0;
    check("t2_len", 32'(len_q.size() ? len_q[$] : -1), 32'd11);
    check("t2_id", 32'(id_q.size() ? id_q[$] : -1), 32'd0);
    tick(); tick();

    // T4: pause 5 cycles at q=4.
    bus.req = 4'b0001;
    reset_dut();
    begin
      int paused;
      bit seen;
      paused = 0; seen = 0;
      for (int c = 0; c < 60 && !seen; c++) begin
        tick();
        seen = bus.done;
        if (m_run && m_q == 4 && paused < 5) begin
          bus.enable = 1'b0; paused++;
        end else begin
          bus.enable = 1'b1;
        end
      end
      check("t4_timeout", 32'(seen), 32'd1);
    end
    bus.enable = 1'b1;
    bus.req = '0;
    check("t4_len", 32'(len_q.size() ? len_q[$] : -1), 32'd16);

    // T5: limit 0 on requester 2.
    bus.req = 4'b0100;
    set_limit(2, 0);
    reset_dut();
    run_until_done("t5_timeout", 10);
    bus.req = '0;
    check("t5_len", 32'(len_q.size() ? len_q[$] : -1), 32'd1);
    check("t5_id", 32'(id_q.size() ? id_q[$] : -1), 32'd2);

    // Full-width limit: 256-cycle run without overflow.
    bus.req = 4'b1000;
    set_limit(3, 255);
    reset_dut();
    run_until_done("wrap_timeout", 300);
    bus.req = '0;
    check("wrap_len", 32'(len_q.size() ? len_q[$] : -1), 32'd256);
    check("wrap_id", 32'(id_q.size() ? id_q[$] : -1), 32'd3);

`ifdef CNT_SCHED_ABORT_EN
    // T6: abort requester 1 at q=3, pointer moves to 2.
    bus.req = 4'b0010;
    set_limit(1, 10);
    reset_dut();
    begin
      bit hit;
      hit = 0;
      for (int c = 0; c < 20 && !hit; c++) begin
        tick();
        hit = m_run && m_q == 3;
      end
      check("t6_reach", 32'(hit), 32'd1);
    end
    bus.req = '0;
    tick();
    check("t6_gnt", 32'(bus.gnt), 32'd0);
    check("t6_done", 32'(bus.done), 32'd0);
    bus.req = 4'b0111;
    tick();
    check("t6_next", 32'(onehot_idx(bus.gnt)), 32'd2);
    bus.req = '0;
`endif

    // Randomized traffic against the model.
    reset_dut();
    for (int c = 0; c < 1500; c++) begin
      rst        = ($urandom_range(0, 99) != 0);
      bus.enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) bus.req = N_REQ'($urandom);
      if ($urandom_range(0, 7) == 0)
        set_limit($urandom_range(0, N_REQ - 1),
                  ($urandom_range(0, 31) == 0) ? 255 : $urandom_range(0, 7));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
